// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (MIPS R-type subset) with valid/ready handshakes on
// both sides. S1 holds the accepted operands, S2 holds the registered result and flags.
module alu_pipe #(
  parameter int OPERAND_SIZE = 8,
  parameter int OP_CODE_SIZE = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [OPERAND_SIZE-1:0] dato_a,
  input  logic [OPERAND_SIZE-1:0] dato_b,
  input  logic [OP_CODE_SIZE-1:0] op_code,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [OPERAND_SIZE-1:0] o_resultado,
  output logic                    o_carry,
  output logic                    o_overflow,
  output logic                    o_zero,
  output logic                    o_negative,
  output logic                    o_illegal
);

  localparam int W   = OPERAND_SIZE;
  localparam int SHW = $clog2(OPERAND_SIZE);

  localparam logic [OP_CODE_SIZE-1:0] OP_ADD = OP_CODE_SIZE'(6'b100000);
  localparam logic [OP_CODE_SIZE-1:0] OP_SUB = OP_CODE_SIZE'(6'b100010);
  localparam logic [OP_CODE_SIZE-1:0] OP_AND = OP_CODE_SIZE'(6'b100100);
  localparam logic [OP_CODE_SIZE-1:0] OP_OR  = OP_CODE_SIZE'(6'b100101);
  localparam logic [OP_CODE_SIZE-1:0] OP_XOR = OP_CODE_SIZE'(6'b100110);
  localparam logic [OP_CODE_SIZE-1:0] OP_NOR = OP_CODE_SIZE'(6'b100111);
  localparam logic [OP_CODE_SIZE-1:0] OP_SLT = OP_CODE_SIZE'(6'b101010);
  localparam logic [OP_CODE_SIZE-1:0] OP_SLL = OP_CODE_SIZE'(6'b000000);
  localparam logic [OP_CODE_SIZE-1:0] OP_SRL = OP_CODE_SIZE'(6'b000010);
  localparam logic [OP_CODE_SIZE-1:0] OP_SRA = OP_CODE_SIZE'(6'b000011);

  logic                    r_s1_valid;
  logic [W-1:0]            r_s1_a;
  logic [W-1:0]            r_s1_b;
  logic [OP_CODE_SIZE-1:0] r_s1_op;

  logic                    r_s2_valid;
  logic [W-1:0]            r_s2_res;
  logic                    r_s2_carry;
  logic                    r_s2_ovf;
  logic                    r_s2_zero;
  logic                    r_s2_neg;
  logic                    r_s2_ill;

  logic                    w_s2_en;
  logic                    w_s1_en;
  logic                    w_accept;

  logic [SHW-1:0]          w_shamt;
  logic [W:0]              w_sum;
  logic [W:0]              w_diff;
  logic [W:0]              w_shl;
  logic [W:0]              w_shr;
  logic [W:0]              w_sra;
  logic                    w_slt;
  logic [W-1:0]            w_res;
  logic                    w_carry;
  logic                    w_ovf;
  logic                    w_ill;
  logic                    w_zero;
  logic                    w_neg;

  // Handshake: a stage may load when it is empty or the stage after it moves.
  assign w_s2_en  = ~r_s2_valid | i_ready;
  assign w_s1_en  = ~r_s1_valid | w_s2_en;
  assign o_ready  = w_s1_en & ~i_flush;
  assign w_accept = i_valid & o_ready;

  // Shifts run one bit wider so the last bit shifted out lands in the extra bit
  // (and is naturally 0 for a zero shift amount).
  assign w_shamt = r_s1_b[SHW-1:0];
  assign w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff  = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_shl   = {1'b0, r_s1_a} << w_shamt;
  assign w_shr   = {r_s1_a, 1'b0} >> w_shamt;
  assign w_sra   = $unsigned($signed({r_s1_a, 1'b0}) >>> w_shamt);
  assign w_slt   = $signed(r_s1_a) < $signed(r_s1_b);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
        w_ovf   = (r_s1_a[W-1] == r_s1_b[W-1]) & (w_sum[W-1] != r_s1_a[W-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[W-1:0];
        w_carry = w_diff[W];
        w_ovf   = (r_s1_a[W-1] != r_s1_b[W-1]) & (w_diff[W-1] != r_s1_a[W-1]);
      end
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
      OP_SLT:  w_res = {{(W-1){1'b0}}, w_slt};
      OP_SLL: begin
        w_res   = w_shl[W-1:0];
        w_carry = w_shl[W];
      end
      OP_SRL: begin
        w_res   = w_shr[W:1];
        w_carry = w_shr[0];
      end
      OP_SRA: begin
        w_res   = w_sra[W:1];
        w_carry = w_sra[0];
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);
  assign w_neg  = w_res[W-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= i_valid;
      if (w_accept) begin
        r_s1_a  <= dato_a;
        r_s1_b  <= dato_b;
        r_s1_op <= op_code;
      end
    end
  end

  // S2 payload only reloads when S1 actually hands over an op.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_carry <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_neg   <= 1'b0;
      r_s2_ill   <= 1'b0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res   <= w_res;
        r_s2_carry <= w_carry;
        r_s2_ovf   <= w_ovf;
        r_s2_zero  <= w_zero;
        r_s2_neg   <= w_neg;
        r_s2_ill   <= w_ill;
      end
    end
  end

  assign o_valid     = r_s2_valid;
  assign o_resultado = r_s2_res;
  assign o_carry     = r_s2_carry;
  assign o_overflow  = r_s2_ovf;
  assign o_zero      = r_s2_zero;
  assign o_negative  = r_s2_neg;
  assign o_illegal   = r_s2_ill;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                         OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                         SLT = 6'b101010, SLL = 6'b000000, SRL = 6'b000010,
                         SRA = 6'b000011;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    exp_t       e;
  } dvec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_flush, i_valid, i_ready;
  logic       o_ready, o_valid;
  logic [7:0] dato_a, dato_b, o_resultado;
  logic [5:0] op_code;
  logic       o_carry, o_overflow, o_zero, o_negative, o_illegal;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic obs_ready, obs_valid, acc, ret, have_exp;
  exp_t obs, exp_ret;

  alu_pipe #(.OPERAND_SIZE(8), .OP_CODE_SIZE(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .dato_a(dato_a), .dato_b(dato_b), .op_code(op_code),
    .o_valid(o_valid), .i_ready(i_ready), .o_resultado(o_resultado),
    .o_carry(o_carry), .o_overflow(o_overflow), .o_zero(o_zero),
    .o_negative(o_negative), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int   ua, ub, sa, sb, r, s;
    exp_t e;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    s  = ub % 8;
    e  = '0;
    r  = 0;
    case (op)
      ADD:  begin r = ua + ub; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
      SUB:  begin r = ua - ub; e.c = (ua < ub); e.v = (sa - sb > 127) || (sa - sb < -128); end
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      NOR_: r = ~(ua | ub);
      SLT:  r = (sa < sb) ? 1 : 0;
      SLL:  begin r = ua << s;  e.c = (s != 0) && (((ua >> (8 - s)) & 1) == 1); end
      SRL:  begin r = ua >> s;  e.c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      SRA:  begin r = sa >>> s; e.c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    r     = r & 255;
    e.res = 8'(r);
    e.z   = (r == 0);
    e.n   = (r > 127);
    return e;
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 10))
      0: return ADD;   1: return SUB;  2: return AND_; 3: return OR_;
      4: return XOR_;  5: return NOR_; 6: return SLT;  7: return SLL;
      8: return SRL;   9: return SRA;
      default: return 6'($urandom);
    endcase
  endfunction

  // One clock: drive inputs at the falling edge, sample, track the handshake,
  // advance to the next falling edge. Does no checking itself.
  task automatic step(input logic v, input logic [7:0] va, input logic [7:0] vb,
                      input logic [5:0] vop, input logic rdy, input logic fl);
    i_valid = v; dato_a = va; dato_b = vb; op_code = vop; i_ready = rdy; i_flush = fl;
    #1;
    obs_ready = o_ready;
    obs_valid = o_valid;
    obs       = {o_resultado, o_carry, o_overflow, o_zero, o_negative, o_illegal};
    acc       = v & o_ready;
    ret       = o_valid & rdy;
    have_exp  = 1'b0;
    if (ret && exp_q.size() > 0) begin
      exp_ret  = exp_q.pop_front();
      have_exp = 1'b1;
    end
    if (acc) exp_q.push_back(model(va, vb, vop));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_single(input logic [7:0] va, input logic [7:0] vb, input logic [5:0] vop,
                            output exp_t got, output int lat);
    got = '0;
    lat = -1;
    step(1'b1, va, vb, vop, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 8'h00, 8'h00, ADD, 1'b1, 1'b0);
      if (obs_valid) begin
        got = obs;
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    dato_a = '0; dato_b = '0; op_code = '0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
    n_tests++;
    if ({o_resultado, o_carry, o_overflow, o_zero, o_negative, o_illegal} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h exp 0", {o_resultado, o_carry, o_overflow, o_zero, o_negative, o_illegal});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    dvec_t dv[12];
    exp_t  got;
    int    lat;
    dv[0]  = '{8'h7F, 8'h01, ADD,  {8'h80, 5'b01010}};
    dv[1]  = '{8'h00, 8'h01, SUB,  {8'hFF, 5'b10010}};
    dv[2]  = '{8'hFF, 8'h01, SLT,  {8'h01, 5'b00000}};
    dv[3]  = '{8'h81, 8'h01, SRA,  {8'hC0, 5'b10010}};
    dv[4]  = '{8'h81, 8'h01, SRL,  {8'h40, 5'b10000}};
    dv[5]  = '{8'h81, 8'h00, SLL,  {8'h81, 5'b00010}};
    dv[6]  = '{8'h5A, 8'hA5, 6'h3F, {8'h00, 5'b00101}};
    dv[7]  = '{8'hFF, 8'h0F, AND_, {8'h0F, 5'b00000}};
    dv[8]  = '{8'hFF, 8'h01, ADD,  {8'h00, 5'b10100}};
    dv[9]  = '{8'h80, 8'h01, SUB,  {8'h7F, 5'b01000}};
    dv[10] = '{8'h00, 8'h00, NOR_, {8'hFF, 5'b00010}};
    dv[11] = '{8'h81, 8'h01, SLL,  {8'h02, 5'b10000}};
    for (int i = 0; i < 12; i++) begin
      run_single(dv[i].a, dv[i].b, dv[i].op, got, lat);
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d exp 2", i, lat); end
      n_tests++;
      if (got !== dv[i].e) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h exp %h", i, got, dv[i].e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[8], bv[8];
    int sent = 0, got = 0;
    for (int i = 0; i < 8; i++) begin av[i] = 8'($urandom); bv[i] = 8'($urandom); end
    for (int c = 0; c < 40 && got < 8; c++) begin
      step(sent < 8, av[sent % 8], bv[sent % 8], ADD, !(c >= 3 && c <= 5), 1'b0);
      if (acc) sent++;
      if (c == 2) begin
        n_tests++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_no_bubble: ready %b valid %b exp 1 1", obs_ready, obs_valid);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got %b exp 0", obs_ready); end
      end
      if (c == 6) begin
        n_tests++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resume_ready: got %b exp 1", obs_ready); end
      end
      if (ret) begin
        got++;
        n_tests++;
        if (!have_exp || obs !== exp_ret) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h exp %h (have %b)", got, obs, exp_ret, have_exp);
        end
      end
    end
    n_tests++;
    if (got !== 8 || sent !== 8) begin n_fail++; $display("FAIL b2b_count: retired %0d sent %0d exp 8 8", got, sent); end
    step(1'b0, 8'h00, 8'h00, ADD, 1'b1, 1'b0);
    n_tests++;
    if (obs_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_duplicate: valid %b pending %0d exp 0 0", obs_valid, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic prev_hold = 1'b0;
    exp_t prev_obs  = '0;
    logic rdy;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), pick_op(), rdy, 1'b0);
      if (prev_hold) begin
        n_tests++;
        if (obs_valid !== 1'b1 || obs !== prev_obs) begin
          n_fail++;
          $display("FAIL random_hold: valid %b got %h exp 1 %h", obs_valid, obs, prev_obs);
        end
      end
      if (ret) begin
        n_tests++;
        if (!have_exp || obs !== exp_ret) begin
          n_fail++;
          $display("FAIL random_result: got %h exp %h (have %b)", obs, exp_ret, have_exp);
        end
      end
      prev_hold = obs_valid & ~rdy;
      prev_obs  = obs;
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h00, 8'h00, ADD, 1'b1, 1'b0);
      if (ret) begin
        n_tests++;
        if (!have_exp || obs !== exp_ret) begin
          n_fail++;
          $display("FAIL drain_result: got %h exp %h (have %b)", obs, exp_ret, have_exp);
        end
      end
    end
    n_tests++;
    if (obs_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: valid %b pending %0d exp 0 0", obs_valid, exp_q.size());
    end
  endtask

  task automatic test_flush();
    exp_t got;
    int   lat;
    step(1'b1, 8'h11, 8'h22, ADD, 1'b0, 1'b0);
    step(1'b1, 8'h33, 8'h44, XOR_, 1'b0, 1'b0);
    step(1'b1, 8'h55, 8'h66, OR_, 1'b0, 1'b1);
    n_tests++;
    if (obs_valid !== 1'b1 || obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_entry: valid %b ready %b exp 1 0", obs_valid, obs_ready);
    end
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 8'h00, 8'h00, ADD, 1'b1, 1'b0);
      n_tests++;
      if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid[%0d]: got %b exp 0", c, obs_valid); end
    end
    run_single(8'h0C, 8'h03, SUB, got, lat);
    n_tests++;
    if (lat !== 2 || got !== model(8'h0C, 8'h03, SUB)) begin
      n_fail++;
      $display("FAIL flush_recover: got %h lat %0d exp %h lat 2", got, lat, model(8'h0C, 8'h03, SUB));
    end
  endtask

  task automatic test_reset_midop();
    exp_t got;
    int   lat;
    step(1'b1, 8'h01, 8'h02, ADD, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 8'h04, SRA, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL midop_filled: got %b exp 1", o_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || {o_resultado, o_carry, o_overflow, o_zero, o_negative, o_illegal} !== 13'h0) begin
      n_fail++;
      $display("FAIL midop_reset: valid %b out %h exp 0 0", o_valid,
               {o_resultado, o_carry, o_overflow, o_zero, o_negative, o_illegal});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 8'h00, 8'h00, ADD, 1'b1, 1'b0);
      n_tests++;
      if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL midop_ghost[%0d]: got %b exp 0", c, obs_valid); end
    end
    run_single(8'h9C, 8'h65, SLT, got, lat);
    n_tests++;
    if (lat !== 2 || got !== model(8'h9C, 8'h65, SLT)) begin
      n_fail++;
      $display("FAIL midop_recover: got %h lat %0d exp %h lat 2", got, lat, model(8'h9C, 8'h65, SLT));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
